// File: rtl/fifo_fwft_occ.sv
// First-word-fall-through FIFO using all DEPTH slots, with an occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_fwft_occ #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 4,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             almost_empty,
  output logic [PW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = PW + 1;
  localparam logic [PW:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PW:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode the registered count only, so there is no path from wr_en/rd_en.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign dout = mem[head];

  always_ff @(posedge clk) begin
    if (wr_acc && !flush && !srst) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) tail <= tail + 1'b1;
      if (rd_acc) head <= head + 1'b1;

      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (!wr_acc && rd_acc) begin
        count <= count - 1'b1;
      end

      // A new error event in the same cycle as clr_err keeps the flag set.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_occ.sv
// Scoreboard bench for fifo_fwft_occ: directed scenarios followed by randomized
// traffic, checked against a queue-based occupancy/flag model.
module tb_fifo_fwft_occ;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic             flush = 1'b0;
  logic             clr_err = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic             full, almost_full, empty, almost_empty, overflow, underflow;
  logic [WIDTH-1:0] dout;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  // Reference state: occupancy, error flags, and data expected on dout.
  int               m_count = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic [WIDTH-1:0] sb [$];

  fifo_fwft_occ #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .srst(srst), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: inputs are stable well away from the edge, so it reads them at posedge.
  always @(posedge clk) begin
    bit wa, ra;
    if (srst) begin
      m_count = 0; m_ovf = 0; m_unf = 0;
      sb.delete();
    end else if (flush) begin
      m_count = 0;
      sb.delete();
    end else begin
      wa = wr_en && (m_count < DEPTH);
      ra = rd_en && (m_count > 0);
      if (wr_en && m_count == DEPTH) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (rd_en && m_count == 0) m_unf = 1;
      else if (clr_err) m_unf = 0;
      if (wa) sb.push_back(din);
      m_count = m_count + int'(wa) - int'(ra);
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard on each read the DUT will take.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    chk("count", int'(count), m_count);
    chk("empty", int'(empty), int'(m_count == 0));
    chk("full", int'(full), int'(m_count == DEPTH));
    chk("almost_full", int'(almost_full), int'(m_count >= AF));
    chk("almost_empty", int'(almost_empty), int'(m_count <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
    if (rd_en && !empty && !srst && !flush) begin
      if (sb.size() == 0) begin
        chk("dout_unexpected_read", 1, 0);
      end else begin
        exp_d = sb.pop_front();
        chk("dout", int'(dout), int'(exp_d));
      end
    end
  end

  task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0, input logic s = 1'b0);
    @(posedge clk);
    #2;
    wr_en = w; din = d; rd_en = r; flush = f; clr_err = c; srst = s;
  endtask

  initial begin
    int wp, rp;
    drive(0, 8'h00, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1);

    // Fill and wrap
    drive(1, 8'h11, 0); drive(1, 8'h22, 0); drive(1, 8'h33, 0); drive(1, 8'h44, 0);
    drive(0, 8'h00, 1); drive(0, 8'h00, 1);
    drive(1, 8'h55, 0); drive(1, 8'h66, 0);
    repeat (4) drive(0, 8'h00, 1);

    // Full with simultaneous read and write: 0x77 dropped, overflow set
    drive(1, 8'hA0, 0); drive(1, 8'hA1, 0); drive(1, 8'hA2, 0); drive(1, 8'hA3, 0);
    drive(1, 8'h77, 1);
    repeat (3) drive(0, 8'h00, 1);

    // Empty with simultaneous read and write: only write taken, underflow set
    drive(1, 8'hA5, 1);
    drive(1, 8'hB0, 0, 0, 1);

    // Steady streaming at count 2
    for (int i = 0; i < 10; i++) drive(1, WIDTH'(i), 1);

    // Flush and clear
    drive(1, 8'hC0, 0); drive(1, 8'hC1, 0); drive(1, 8'hC2, 0);
    drive(0, 8'h00, 1);
    drive(1, 8'hC3, 0);
    drive(1, 8'hEE, 1, 1);
    drive(0, 8'h00, 0, 0, 1);
    drive(1, 8'hD0, 0);
    drive(0, 8'h00, 0);

    // Randomized traffic with phases biased toward full, empty and balanced
    for (int i = 0; i < 800; i++) begin
      case ((i / 50) % 4)
        0: begin wp = 85; rp = 20; end
        1: begin wp = 20; rp = 85; end
        2: begin wp = 60; rp = 60; end
        default: begin wp = 95; rp = 95; end
      endcase
      drive($urandom_range(99) < wp, WIDTH'($urandom), $urandom_range(99) < rp,
            $urandom_range(99) == 0, $urandom_range(99) < 3, $urandom_range(299) == 0);
    end

    drive(0, 8'h00, 0);
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
